// File: rtl/ifu_prefetch_if.sv
// Instruction-memory channel between the fetch unit and instruction memory.
// Request: valid/ready handshake carrying the fetch address.
// Response: in-order, one instruction per cycle, no back-pressure and no tag.
//   master : fetch unit (drives req_valid_o/req_addr_o, receives ready and responses)
//   slave  : instruction memory
interface ifu_prefetch_if #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned INST_W = 32
);
    logic              req_valid_o;
    logic [ADDR_W-1:0] req_addr_o;
    logic              req_ready_i;
    logic              rsp_valid_i;
    logic [INST_W-1:0] rsp_data_i;

    modport master (
        output req_valid_o,
        output req_addr_o,
        input  req_ready_i,
        input  rsp_valid_i,
        input  rsp_data_i
    );

    modport slave (
        input  req_valid_o,
        input  req_addr_o,
        output req_ready_i,
        output rsp_valid_i,
        output rsp_data_i
    );
endinterface

// File: rtl/ifu_prefetch.sv
// Instruction-fetch unit with an in-order prefetch queue.
// Generates fetch PCs (steered by the predictor), issues them over the
// memory channel, buffers up to DEPTH instructions and presents the head
// entry to decode. Flush / EX redirect empty the queue; responses still in
// flight are absorbed by drop_cnt since responses carry no tag.
// Ports:
//   clk_i, n_rst_i                     clock, async active-low reset
//   stall_i[0]                         decode does not accept the head
//   flush_i / new_pc_i                 pipeline flush and target (highest priority)
//   branch_redirect_i / _pc_i          EX mispredict redirect and target
//   next_pc_i / next_taken_i           predictor result for the current fetch PC
//   mem                                request/response channel (master side)
//   valid_o, pc_o, inst_o              head entry to decode
//   next_pc_o, next_taken_o            prediction recorded at issue
//   branch_slot_end_o                  head is first instruction after a redirect
//   stall_req_o                        ~valid_o
module ifu_prefetch #(
    parameter int unsigned       ADDR_W   = 32,
    parameter int unsigned       INST_W   = 32,
    parameter int unsigned       DEPTH    = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk_i,
    input  logic              n_rst_i,
    input  logic [5:0]        stall_i,
    input  logic              flush_i,
    input  logic [ADDR_W-1:0] new_pc_i,
    input  logic              branch_redirect_i,
    input  logic [ADDR_W-1:0] branch_redirect_pc_i,
    input  logic [ADDR_W-1:0] next_pc_i,
    input  logic              next_taken_i,
    ifu_prefetch_if.master    mem,
    output logic              valid_o,
    output logic [ADDR_W-1:0] pc_o,
    output logic [INST_W-1:0] inst_o,
    output logic [ADDR_W-1:0] next_pc_o,
    output logic              next_taken_o,
    output logic              branch_slot_end_o,
    output logic              stall_req_o
);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam int unsigned SUM_W = CNT_W + 1;

    typedef struct packed {
        logic [ADDR_W-1:0] pc;
        logic [ADDR_W-1:0] next_pc;
        logic              taken;
        logic              slot_end;
        logic [INST_W-1:0] inst;
        logic              filled;
    } entry_t;

    entry_t            ent_q [DEPTH];
    entry_t            ent_d [DEPTH];
    // Pointers carry one extra wrap bit so occupancy is a plain difference.
    logic [CNT_W-1:0]  alloc_q, alloc_d;
    logic [CNT_W-1:0]  fill_q, fill_d;
    logic [CNT_W-1:0]  head_q, head_d;
    logic [CNT_W-1:0]  drop_q, drop_d;
    logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
    logic              redir_pend_q, redir_pend_d;

    logic [CNT_W-1:0]  count_c;
    logic [CNT_W-1:0]  unfilled_c;
    logic [SUM_W-1:0]  drop_sum_c;
    logic [PTR_W-1:0]  alloc_idx_c, fill_idx_c, head_idx_c;
    entry_t            head_ent_c;
    logic              req_valid_c, accept_c, valid_c, consume_c, kill_c;
    logic              unused_stall_bits;

    assign unused_stall_bits = ^stall_i[5:1];

    // Occupancy, head view and handshake decisions.
    assign count_c     = alloc_q - head_q;
    assign unfilled_c  = alloc_q - fill_q;
    assign alloc_idx_c = alloc_q[PTR_W-1:0];
    assign fill_idx_c  = fill_q[PTR_W-1:0];
    assign head_idx_c  = head_q[PTR_W-1:0];
    assign head_ent_c  = ent_q[head_idx_c];
    assign kill_c      = flush_i | branch_redirect_i;
    // Dropped responses still occupy memory bandwidth, so they count against DEPTH.
    assign req_valid_c = ~kill_c & ((SUM_W'(count_c) + SUM_W'(drop_q)) < SUM_W'(DEPTH));
    assign accept_c    = req_valid_c & mem.req_ready_i;
    assign valid_c     = (count_c != '0) & head_ent_c.filled;
    assign consume_c   = valid_c & ~stall_i[0];

    assign mem.req_valid_o = req_valid_c;
    assign mem.req_addr_o  = fetch_pc_q;

    assign valid_o           = valid_c;
    assign stall_req_o       = ~valid_c;
    assign pc_o              = valid_c ? head_ent_c.pc       : '0;
    assign inst_o            = valid_c ? head_ent_c.inst     : '0;
    assign next_pc_o         = valid_c ? head_ent_c.next_pc  : '0;
    assign next_taken_o      = valid_c & head_ent_c.taken;
    assign branch_slot_end_o = valid_c & head_ent_c.slot_end;

    // Everything still outstanding after a kill; the response arriving now is one of them.
    always_comb begin
        drop_sum_c = SUM_W'(drop_q) + SUM_W'(unfilled_c);
        if (mem.rsp_valid_i && (drop_sum_c != '0)) begin
            drop_sum_c = drop_sum_c - SUM_W'(1);
        end
    end

    // Next-state logic.
    always_comb begin
        ent_d        = ent_q;
        alloc_d      = alloc_q;
        fill_d       = fill_q;
        head_d       = head_q;
        drop_d       = drop_q;
        fetch_pc_d   = fetch_pc_q;
        redir_pend_d = redir_pend_q;

        if (kill_c) begin
            ent_d        = '{default: '0};
            alloc_d      = '0;
            fill_d       = '0;
            head_d       = '0;
            drop_d       = CNT_W'(drop_sum_c);
            fetch_pc_d   = flush_i ? new_pc_i : branch_redirect_pc_i;
            redir_pend_d = ~flush_i;
        end else begin
            if (mem.rsp_valid_i) begin
                if (drop_q != '0) begin
                    drop_d = drop_q - CNT_W'(1);
                end else if (unfilled_c != '0) begin
                    ent_d[fill_idx_c].inst   = mem.rsp_data_i;
                    ent_d[fill_idx_c].filled = 1'b1;
                    fill_d                   = fill_q + CNT_W'(1);
                end
            end
            // Head is always filled and never aliases alloc/fill slots when consumed.
            if (consume_c) begin
                ent_d[head_idx_c] = '0;
                head_d            = head_q + CNT_W'(1);
            end
            if (accept_c) begin
                ent_d[alloc_idx_c].pc       = fetch_pc_q;
                ent_d[alloc_idx_c].next_pc  = next_pc_i;
                ent_d[alloc_idx_c].taken    = next_taken_i;
                ent_d[alloc_idx_c].slot_end = redir_pend_q;
                ent_d[alloc_idx_c].inst     = '0;
                ent_d[alloc_idx_c].filled   = 1'b0;
                alloc_d                     = alloc_q + CNT_W'(1);
                redir_pend_d                = 1'b0;
                fetch_pc_d                  = next_taken_i ? next_pc_i
                                                           : fetch_pc_q + ADDR_W'(4);
            end
        end
    end

    // State registers.
    always_ff @(posedge clk_i or negedge n_rst_i) begin
        if (!n_rst_i) begin
            ent_q        <= '{default: '0};
            alloc_q      <= '0;
            fill_q       <= '0;
            head_q       <= '0;
            drop_q       <= '0;
            fetch_pc_q   <= RESET_PC;
            redir_pend_q <= 1'b0;
        end else begin
            ent_q        <= ent_d;
            alloc_q      <= alloc_d;
            fill_q       <= fill_d;
            head_q       <= head_d;
            drop_q       <= drop_d;
            fetch_pc_q   <= fetch_pc_d;
            redir_pend_q <= redir_pend_d;
        end
    end
endmodule

// File: doc/ifu_prefetch.md
# ifu_prefetch

Parametrised instruction-fetch unit with an in-order prefetch queue. It generates fetch PCs, steered by the branch predictor, and issues them to instruction memory over a valid/ready request channel with variable-latency in-order responses. It buffers up to DEPTH instructions and presents them to decode. Flush and EX branch redirects discard the queue, and responses still in flight are dropped without a response tag.

## Interface
- ADDR_W, 32, PC/address width
- INST_W, 32, instruction width
- DEPTH, 4, queue entries and maximum outstanding requests; power of 2, ≥2
- RESET_PC, 0, first fetch address after reset
- clk_i  in  1  clock; all state updates on the rising edge
- n_rst_i  in  1  asynchronous active-low reset
- stall_i  in  6  bit 0 = 1: decode does not accept this cycle; bits 5:1 unused
- flush_i  in  1  pipeline flush, highest priority
- new_pc_i  in  ADDR_W  flush target
- branch_redirect_i  in  1  EX mispredict redirect
- branch_redirect_pc_i  in  ADDR_W  redirect target
- next_pc_i  in  ADDR_W  predictor target for req_addr_o, same cycle
- next_taken_i  in  1  predictor says req_addr_o is a taken branch
- req_valid_o  out  1  fetch request valid
- req_addr_o  out  ADDR_W  fetch address; equals fetch_pc
- req_ready_i  in  1  memory accepts request
- rsp_valid_i  in  1  response valid; responses arrive in request order, ≥1 cycle after acceptance
- rsp_data_i  in  INST_W  fetched instruction
- valid_o  out  1  head entry filled
- pc_o  out  ADDR_W  head PC
- inst_o  out  INST_W  head instruction
- next_pc_o / next_taken_o  out  ADDR_W / 1  prediction recorded at issue, for EX check
- branch_slot_end_o  out  1  head is the first instruction after a redirect
- stall_req_o  out  1  equals ~valid_o

## Operation
- State: fetch_pc; circular queue of DEPTH entries {pc, next_pc, taken, slot_end, inst, filled}; alloc/fill/head pointers; count; drop_cnt (0..DEPTH); redir_pend flag.
- Issue: req_valid_o = ~flush_i & ~branch_redirect_i & (count + drop_cnt < DEPTH).
- On accept (req_valid_o & req_ready_i):
  - Allocate entry at alloc: pc = fetch_pc; next_pc/taken from the predictor; slot_end = redir_pend; filled = 0.
  - Clear redir_pend.
  - Update fetch_pc to next_pc_i when taken, else fetch_pc + 4. The add is modulo 2^ADDR_W.
- Response:
  - If drop_cnt > 0, decrement drop_cnt and discard the data.
  - Otherwise write inst into the fill entry, set filled, and advance fill.
  - A response with no unfilled entry and drop_cnt = 0 is a protocol error. It is ignored.
- Consume: when valid_o & ~stall_i[0], retire the head and advance head.
- Outputs are taken from the head entry. When valid_o = 0, pc_o, inst_o, next_pc_o, next_taken_o and branch_slot_end_o are 0.
- Flush (flush_i):
  - Clear all entries and zero the pointers.
  - Set drop_cnt ← drop_cnt + unfilled_entries − (rsp_valid_i ? 1 : 0). This drops the response arriving this cycle and every response still in flight.
  - Set fetch_pc ← new_pc_i and clear redir_pend.
- Redirect (branch_redirect_i without flush_i): same as flush, but fetch_pc ← branch_redirect_pc_i and redir_pend ← 1.
- Priority: flush > redirect > response/consume/issue. In a flush or redirect cycle a consume is ignored and the head is discarded.
- Count updates: +1 on accept, −1 on consume, both in the same cycle → unchanged.

## Timing
- Reset values:
  - fetch_pc = RESET_PC; queue empty; drop_cnt = 0; redir_pend = 0.
  - valid_o = 0, stall_req_o = 1, req_valid_o = 1 (while req_ready_i is sampled), all data outputs 0.
- First request is issued in the first cycle after reset deasserts.
- Latency: request accepted in cycle t, response in cycle t+L → valid_o = 1 in cycle t+L+1.
- Throughput is 1 instruction/cycle when L ≤ DEPTH−1 and stall_i[0] = 0.
- After flush or redirect in cycle t:
  - First new request is in cycle t+1.
  - Old in-flight responses are absorbed by drop_cnt, which can delay issue because count + drop_cnt < DEPTH.
- Reset asserted mid-operation clears everything immediately. In-flight responses after reset are not tracked; memory is reset together with this block.
- Full queue: req_valid_o = 0 until a consume frees an entry. It reasserts the cycle after the consume edge.

## Test plan
- Reset release, RESET_PC = 0x0, L = 1, ready always 1, no stall → requests 0x0, 0x4, 0x8… on consecutive cycles; valid_o from cycle 3; pc_o steps by 4 each cycle.
- next_taken_i = 1 at 0x8 with next_pc_i = 0x100 → request sequence 0x0, 0x4, 0x8, 0x100; head entry 0x8 shows next_taken_o = 1, next_pc_o = 0x100.
- stall_i[0] = 1 held, DEPTH = 4, L = 1 → exactly 4 requests, then req_valid_o = 0; releasing the stall for one cycle retires 0x0 and allows one more request the following cycle.
- L = 3, 3 requests in flight, branch_redirect_i with pc 0x200 → next 3 responses are dropped (drop_cnt 3 → 0); first valid_o shows pc_o = 0x200, branch_slot_end_o = 1; the next instruction shows 0.
- flush_i and branch_redirect_i together, new_pc_i = 0x40 → fetch resumes at 0x40; branch_slot_end_o = 0.
- fetch_pc = 2^ADDR_W − 4, not taken → next request to 0x0.
